// File: rtl/brcomp_arb.sv
// Two-port round-robin arbiter in front of one shared branch comparator.
// Each port has a one-entry registered response slot with valid/ready backpressure.
module brcomp_arb #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [XLEN-1:0] req0_rs1_i,
    input  logic [XLEN-1:0] req0_rs2_i,
    input  logic [2:0]      req0_op_i,
    output logic            rsp0_valid_o,
    output logic            rsp0_result_o,
    output logic            rsp0_err_o,
    input  logic            rsp0_ready_i,

    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [XLEN-1:0] req1_rs1_i,
    input  logic [XLEN-1:0] req1_rs2_i,
    input  logic [2:0]      req1_op_i,
    output logic            rsp1_valid_o,
    output logic            rsp1_result_o,
    output logic            rsp1_err_o,
    input  logic            rsp1_ready_i
);

    logic rsp0_valid_q, rsp0_valid_d, rsp0_result_q, rsp0_result_d, rsp0_err_q, rsp0_err_d;
    logic rsp1_valid_q, rsp1_valid_d, rsp1_result_q, rsp1_result_d, rsp1_err_q, rsp1_err_d;
    // Port granted most recently; reset to 1 so port 0 wins the first tie.
    logic last_q, last_d;

    logic elig0, elig1, gnt0, gnt1;

    logic [XLEN-1:0] sel_rs1, sel_rs2;
    logic [2:0]      sel_op;
    logic            br_unsigned, cmp_less, cmp_eq, cmp_result, cmp_err;

    assign elig0 = req0_valid_i && (!rsp0_valid_q || rsp0_ready_i);
    assign elig1 = req1_valid_i && (!rsp1_valid_q || rsp1_ready_i);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_ni) begin
            if (elig0 && elig1) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
    end

    assign last_d       = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_q);
    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    assign sel_rs1 = gnt1 ? req1_rs1_i : req0_rs1_i;
    assign sel_rs2 = gnt1 ? req1_rs2_i : req0_rs2_i;
    assign sel_op  = gnt1 ? req1_op_i  : req0_op_i;

    assign br_unsigned = sel_op[1] & sel_op[2];
    assign cmp_eq      = (sel_rs1 == sel_rs2);
    assign cmp_less    = br_unsigned ? (sel_rs1 < sel_rs2)
                                     : ($signed(sel_rs1) < $signed(sel_rs2));

    always_comb begin
        cmp_result = 1'b0;
        cmp_err    = 1'b0;
        case (sel_op)
            3'b000:         cmp_result = cmp_eq;
            3'b001:         cmp_result = !cmp_eq;
            3'b100, 3'b110: cmp_result = cmp_less;
            3'b101, 3'b111: cmp_result = !cmp_less;
            default:        cmp_err    = 1'b1;
        endcase
    end

    // A refill takes priority over a drain so both can happen in one cycle.
    always_comb begin
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_err_d    = rsp0_err_q;
        if (gnt0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = cmp_result;
            rsp0_err_d    = cmp_err;
        end else if (rsp0_ready_i) begin
            rsp0_valid_d  = 1'b0;
        end
    end

    always_comb begin
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_err_d    = rsp1_err_q;
        if (gnt1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = cmp_result;
            rsp1_err_d    = cmp_err;
        end else if (rsp1_ready_i) begin
            rsp1_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= 1'b0;
            rsp0_err_q    <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= 1'b0;
            rsp1_err_q    <= 1'b0;
            last_q        <= 1'b1;
        end else begin
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_err_q    <= rsp0_err_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_err_q    <= rsp1_err_d;
            last_q        <= last_d;
        end
    end

    assign rsp0_valid_o  = rsp0_valid_q;
    assign rsp0_result_o = rsp0_result_q;
    assign rsp0_err_o    = rsp0_err_q;
    assign rsp1_valid_o  = rsp1_valid_q;
    assign rsp1_result_o = rsp1_result_q;
    assign rsp1_err_o    = rsp1_err_q;

endmodule

// File: tb/tb_brcomp_arb.sv
// Directed bench for brcomp_arb: reset, latency, round-robin, backpressure,
// op decode and asynchronous reset, against hand-computed expectations.
module tb_brcomp_arb;

    localparam int unsigned XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
    logic [XLEN-1:0] req0_rs1_i, req0_rs2_i, req1_rs1_i, req1_rs2_i;
    logic [2:0]      req0_op_i, req1_op_i;
    logic            rsp0_valid_o, rsp0_result_o, rsp0_err_o, rsp0_ready_i;
    logic            rsp1_valid_o, rsp1_result_o, rsp1_err_o, rsp1_ready_i;

    int n_cmp = 0;
    int n_err = 0;

    brcomp_arb #(.XLEN(XLEN)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req0_valid_i  (req0_valid_i),
        .req0_ready_o  (req0_ready_o),
        .req0_rs1_i    (req0_rs1_i),
        .req0_rs2_i    (req0_rs2_i),
        .req0_op_i     (req0_op_i),
        .rsp0_valid_o  (rsp0_valid_o),
        .rsp0_result_o (rsp0_result_o),
        .rsp0_err_o    (rsp0_err_o),
        .rsp0_ready_i  (rsp0_ready_i),
        .req1_valid_i  (req1_valid_i),
        .req1_ready_o  (req1_ready_o),
        .req1_rs1_i    (req1_rs1_i),
        .req1_rs2_i    (req1_rs2_i),
        .req1_op_i     (req1_op_i),
        .rsp1_valid_o  (rsp1_valid_o),
        .rsp1_result_o (rsp1_result_o),
        .rsp1_err_o    (rsp1_err_o),
        .rsp1_ready_i  (rsp1_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
        req0_valid_i = v;
        req0_rs1_i   = a;
        req0_rs2_i   = b;
        req0_op_i    = op;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
        req1_valid_i = v;
        req1_rs1_i   = a;
        req1_rs2_i   = b;
        req1_op_i    = op;
    endtask

    initial begin
        rst_ni       = 1'b0;
        rsp0_ready_i = 1'b1;
        rsp1_ready_i = 1'b1;
        drive0(1'b1, 32'd1, 32'd2, 3'b100);
        drive1(1'b1, 32'd1, 32'd2, 3'b100);

        // Reset: requests present but ready must stay low
        repeat (3) cyc();
        check("rst_rsp0_valid", rsp0_valid_o, 0);
        check("rst_rsp1_valid", rsp1_valid_o, 0);
        check("rst_rsp0_result", rsp0_result_o, 0);
        check("rst_rsp0_err", rsp0_err_o, 0);
        check("rst_ready0", req0_ready_o, 0);
        check("rst_ready1", req1_ready_o, 0);
        drive0(1'b0, 32'd0, 32'd0, 3'b000);
        drive1(1'b0, 32'd0, 32'd0, 3'b000);
        #2 rst_ni = 1'b1;

        // Idle after release
        repeat (2) cyc();
        check("idle_rsp0_valid", rsp0_valid_o, 0);
        check("idle_rsp1_valid", rsp1_valid_o, 0);
        check("idle_ready0", req0_ready_o, 0);

        // Contention: port 0 EQ 3,3 -> 1; port 1 GEU 0,1 -> 0
        drive0(1'b1, 32'd3, 32'd3, 3'b000);
        drive1(1'b1, 32'd0, 32'd1, 3'b111);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready0", req0_ready_o, (i % 2 == 0) ? 1 : 0);
            check("rr_ready1", req1_ready_o, (i % 2 == 1) ? 1 : 0);
            cyc();
            check("rr_rsp0_valid", rsp0_valid_o, (i % 2 == 0) ? 1 : 0);
            check("rr_rsp1_valid", rsp1_valid_o, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) check("rr_rsp0_result", rsp0_result_o, 1);
            else            check("rr_rsp1_result", rsp1_result_o, 0);
        end
        drive0(1'b0, 32'd0, 32'd0, 3'b000);
        drive1(1'b0, 32'd0, 32'd0, 3'b000);
        cyc();
        check("rr_drain0", rsp0_valid_o, 0);
        check("rr_drain1", rsp1_valid_o, 0);

        // Single port 0: -1 < 1 signed, but not unsigned
        drive0(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
        #1 check("lt_ready0", req0_ready_o, 1);
        check("lt_ready1", req1_ready_o, 0);
        cyc();
        check("lt_valid", rsp0_valid_o, 1);
        check("lt_result", rsp0_result_o, 1);
        check("lt_err", rsp0_err_o, 0);
        drive0(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
        #1 check("ltu_ready0", req0_ready_o, 1);
        cyc();
        check("ltu_valid", rsp0_valid_o, 1);
        check("ltu_result", rsp0_result_o, 0);
        // Signed boundary: INT_MAX >= INT_MIN signed, not unsigned
        drive0(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 3'b101);
        cyc();
        check("ge_result", rsp0_result_o, 1);
        drive0(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 3'b111);
        cyc();
        check("geu_result", rsp0_result_o, 0);
        drive0(1'b0, 32'd0, 32'd0, 3'b000);
        cyc();
        check("single_drain", rsp0_valid_o, 0);

        // Backpressure: fill slot 1 (0x10 <u 0x20 -> 1) with consumer stalled
        rsp1_ready_i = 1'b0;
        drive1(1'b1, 32'h10, 32'h20, 3'b110);
        cyc();
        check("bp_fill_valid", rsp1_valid_o, 1);
        check("bp_fill_result", rsp1_result_o, 1);
        drive1(1'b1, 32'h20, 32'h10, 3'b110);
        drive0(1'b1, 32'd7, 32'd7, 3'b000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready1_low", req1_ready_o, 0);
            check("bp_ready0", req0_ready_o, 1);
            cyc();
            check("bp_rsp1_hold_valid", rsp1_valid_o, 1);
            check("bp_rsp1_hold_result", rsp1_result_o, 1);
            check("bp_rsp0_result", rsp0_result_o, 1);
        end
        rsp1_ready_i = 1'b1;
        #1 check("bp_release_ready1", req1_ready_o, 1);
        check("bp_release_ready0", req0_ready_o, 0);
        cyc();
        check("bp_refill_valid", rsp1_valid_o, 1);
        check("bp_refill_result", rsp1_result_o, 0);
        drive0(1'b0, 32'd0, 32'd0, 3'b000);
        drive1(1'b0, 32'd0, 32'd0, 3'b000);
        cyc();
        check("bp_drain1", rsp1_valid_o, 0);
        check("bp_drain0", rsp0_valid_o, 0);

        // Equality and reserved ops on 0x80000000
        drive0(1'b1, 32'h8000_0000, 32'h8000_0000, 3'b000);
        cyc();
        check("eq_result", rsp0_result_o, 1);
        check("eq_err", rsp0_err_o, 0);
        drive0(1'b1, 32'h8000_0000, 32'h8000_0000, 3'b001);
        cyc();
        check("ne_result", rsp0_result_o, 0);
        drive0(1'b1, 32'h8000_0000, 32'h8000_0000, 3'b011);
        #1 check("rsv_ready0", req0_ready_o, 1);
        cyc();
        check("rsv_valid", rsp0_valid_o, 1);
        check("rsv_result", rsp0_result_o, 0);
        check("rsv_err", rsp0_err_o, 1);
        drive0(1'b1, 32'h8000_0000, 32'h8000_0000, 3'b010);
        cyc();
        check("rsv2_err", rsp0_err_o, 1);
        drive0(1'b0, 32'd0, 32'd0, 3'b000);
        cyc();
        check("rsv_drain", rsp0_valid_o, 0);

        // Async reset mid-flight; last grant was port 0 so the pointer must reload
        rsp0_ready_i = 1'b0;
        drive0(1'b1, 32'd5, 32'd5, 3'b000);
        cyc();
        check("ar_pre_valid", rsp0_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1 check("ar_valid_cleared", rsp0_valid_o, 0);
        check("ar_result_cleared", rsp0_result_o, 0);
        check("ar_ready0", req0_ready_o, 0);
        rsp0_ready_i = 1'b1;
        drive1(1'b1, 32'd1, 32'd9, 3'b100);
        #1 rst_ni = 1'b1;
        #1 check("ar_tie_ready0", req0_ready_o, 1);
        check("ar_tie_ready1", req1_ready_o, 0);
        cyc();
        check("ar_post_valid0", rsp0_valid_o, 1);
        check("ar_post_result0", rsp0_result_o, 1);
        #1 check("ar_next_ready1", req1_ready_o, 1);
        cyc();
        check("ar_post_valid1", rsp1_valid_o, 1);
        check("ar_post_result1", rsp1_result_o, 1);
        drive0(1'b0, 32'd0, 32'd0, 3'b000);
        drive1(1'b0, 32'd0, 32'd0, 3'b000);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/brcomp_arb.md
Name: brcomp_arb

Overview:
- Shares one branch comparator (rs1/rs2 compare, signed/unsigned select, less/equal flags) between two requesters: EX-stage branch unit (port 0) and compare-type ALU path for SLT/SLTU-style ops (port 1).
- Per-port valid/ready request channel and a one-entry registered response slot with backpressure.
- Round-robin arbitration; funct3-style op decode into a taken/true result bit.

Parameters:
- XLEN, 32, operand width for rs1/rs2 and the internal comparator.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req0_valid_i / req1_valid_i  in  1  request present on port 0/1.
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle (grant).
- req0_rs1_i / req1_rs1_i  in  XLEN  first operand.
- req0_rs2_i / req1_rs2_i  in  XLEN  second operand.
- req0_op_i / req1_op_i  in  3  op: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 reserved.
- rsp0_valid_o / rsp1_valid_o  out  1  response slot holds a result.
- rsp0_result_o / rsp1_result_o  out  1  condition true (branch taken / set value).
- rsp0_err_o / rsp1_err_o  out  1  request used a reserved op.
- rsp0_ready_i / rsp1_ready_i  in  1  consumer takes the response this cycle.

Behaviour:
- Reset (rst_ni low, async): rsp*_valid_o=0, rsp*_result_o=0, rsp*_err_o=0, rr pointer=1 (port 0 wins the first tie). ready_o is combinational and 0 while in reset.
- Slot free for port r: !rspr_valid_o || rspr_ready_i. Drain and refill in the same cycle are allowed.
- Eligible r: reqr_valid_i && slot r free.
- Grant, combinational:
  - One eligible port: that port.
  - Both eligible: the port not granted last.
  - None eligible: no grant.
  - At most one grant per cycle. reqr_ready_o = grant r.
  - rr pointer updates only on a grant.
- Comparator select:
  - Mux drives the granted port's rs1/rs2.
  - br_unsigned = op[1] & op[2].
  - Result decode from less/equal flags:
    - EQ: eq. NE: !eq.
    - LT/LTU: less. GE/GEU: !less.
    - Reserved op: result=0, err=1; the request is still accepted and consumes a slot.
- Latency: accept in cycle N, so rspr_valid_o=1 with result/err in cycle N+1.
- Response hold: result, err and valid hold stable until rspr_ready_i=1.
  - Drained with no refill: valid drops next cycle.
  - Drained with refill: valid stays 1 and the new result appears.
- Requester must hold valid/operands/op stable until ready; the block does not check this.
- No starvation: a continuously eligible port is granted within 2 cycles.
- Reset mid-operation: pending responses are discarded and requests in flight are lost. Requesters reissue after reset.
- Signed compare is two's complement on XLEN bits. Unsigned compare is magnitude. Equal ignores signedness.

Test Plan:
- Reset then idle: rst_ni=0 for 3 cycles → all rsp*_valid_o=0 and ready_o=0. After release with no valid: nothing changes.
- Single port 0: rs1=0xFFFFFFFF, rs2=0x00000001, op=100 (LT) → ready0=1 in cycle N; rsp0_valid=1 and result=1 in N+1. Same operands with op=110 (LTU) → result=0.
- Contention: both valid every cycle, rsp*_ready_i=1 → grants alternate 0,1,0,1 starting with port 0. Each response appears exactly 1 cycle after its grant.
- Backpressure: rsp1_ready_i=0 with rsp1 full, req1 valid → ready1=0 each cycle while port 0 keeps being granted. Raise rsp1_ready_i → same-cycle grant to port 1, and rsp1 shows the new result next cycle.
- Equality and reserved op: rs1=rs2=0x80000000, op=000 → result=1. op=001 → result=0. op=011 → result=0, err=1.
- Async reset mid-flight: assert rst_ni low between clock edges while rsp0_valid=1 → rsp0_valid_o=0 immediately, before the next edge. rr pointer back to 1.
